// File: rtl/cacc_ram_fifo_ctrl.sv
// Valid/ready FIFO controller wrapped around an external 1-cycle-latency RAM.
// A 2-entry output buffer is kept topped up by prefetch reads to hide that latency.
module cacc_ram_fifo_ctrl #(
    parameter int DW    = 512,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rst,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    output logic [AW:0]   fifo_cnt,
    output logic [AW-1:0] ram_ra,
    output logic          ram_re,
    input  logic [DW-1:0] ram_dout,
    output logic [AW-1:0] ram_wa,
    output logic          ram_we,
    output logic [DW-1:0] ram_di,
    input  logic [31:0]   pwrbus_ram_pd,
    output logic [31:0]   pwrbus_ram_pd_o
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   ram_cnt_q, ram_cnt_d;
    logic [AW:0]   fifo_cnt_q, fifo_cnt_d;
    logic [1:0]    ob_cnt_q, ob_cnt_d;
    logic          ob_head_q, ob_tail_q;
    logic          inflight_q;
    logic          wr_prdy_q, wr_prdy_d;
    logic [DW-1:0] ob_mem_q [2];

    logic          push, pop, issue;
    logic [2:0]    ob_occ;

    assign push = wr_pvld & wr_prdy_q;
    assign pop  = rd_pvld & rd_prdy;

    // Slots already claimed in the output buffer once this cycle's pop leaves.
    assign ob_occ = {1'b0, ob_cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
    assign issue  = (ram_cnt_q != '0) && (ob_occ < 3'd2);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        end
        rd_ptr_d = rd_ptr_q;
        if (issue) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
        end
        ram_cnt_d  = ram_cnt_q + (AW+1)'(push) - (AW+1)'(issue);
        ob_cnt_d   = ob_cnt_q + 2'(inflight_q) - 2'(pop);
        fifo_cnt_d = ram_cnt_d + (AW+1)'(issue) + (AW+1)'(ob_cnt_d);
        wr_prdy_d  = (ram_cnt_d < (AW+1)'(DEPTH));
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            fifo_cnt_q <= '0;
            ob_cnt_q   <= '0;
            ob_head_q  <= 1'b0;
            ob_tail_q  <= 1'b0;
            inflight_q <= 1'b0;
            wr_prdy_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            fifo_cnt_q <= fifo_cnt_d;
            ob_cnt_q   <= ob_cnt_d;
            inflight_q <= issue;
            wr_prdy_q  <= wr_prdy_d;
            if (inflight_q) begin
                ob_tail_q <= ~ob_tail_q;
            end
            if (pop) begin
                ob_head_q <= ~ob_head_q;
            end
        end
    end

    // Buffer data needs no reset: ob_cnt gates its visibility.
    always_ff @(posedge nvdla_core_clk) begin
        if (inflight_q) begin
            ob_mem_q[ob_tail_q] <= ram_dout;
        end
    end

    assign wr_prdy         = wr_prdy_q;
    assign rd_pvld         = (ob_cnt_q != 2'd0);
    assign rd_pd           = ob_mem_q[ob_head_q];
    assign fifo_cnt        = fifo_cnt_q;
    assign ram_re          = issue;
    assign ram_ra          = rd_ptr_q;
    assign ram_we          = push;
    assign ram_wa          = wr_ptr_q;
    assign ram_di          = wr_pd;
    assign pwrbus_ram_pd_o = pwrbus_ram_pd;

endmodule

// File: tb/tb_cacc_ram_fifo_ctrl.sv
// Bench for cacc_ram_fifo_ctrl: behavioural RAM plus a queue-based FIFO model.
module tb_cacc_ram_fifo_ctrl;

    localparam int DW    = 512;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_pvld = 1'b0;
    logic          wr_prdy;
    logic [DW-1:0] wr_pd = '0;
    logic          rd_pvld;
    logic          rd_prdy = 1'b0;
    logic [DW-1:0] rd_pd;
    logic [AW:0]   fifo_cnt;
    logic [AW-1:0] ram_ra, ram_wa;
    logic          ram_re, ram_we;
    logic [DW-1:0] ram_dout, ram_di;
    logic [31:0]   pwr_i = 32'h0;
    logic [31:0]   pwr_o;

    logic [DW-1:0] mem [DEPTH];

    int ntests = 0;
    int nfail  = 0;
    int nwr = 0, nrd = 0, npop = 0;
    logic last_push, last_pop;
    logic [DW-1:0] q [$];

    always #5 clk = ~clk;

    cacc_ram_fifo_ctrl #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .wr_pvld        (wr_pvld),
        .wr_prdy        (wr_prdy),
        .wr_pd          (wr_pd),
        .rd_pvld        (rd_pvld),
        .rd_prdy        (rd_prdy),
        .rd_pd          (rd_pd),
        .fifo_cnt       (fifo_cnt),
        .ram_ra         (ram_ra),
        .ram_re         (ram_re),
        .ram_dout       (ram_dout),
        .ram_wa         (ram_wa),
        .ram_we         (ram_we),
        .ram_di         (ram_di),
        .pwrbus_ram_pd  (pwr_i),
        .pwrbus_ram_pd_o(pwr_o)
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ram_dout <= mem[ram_ra];
    end

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic clear_model();
        q.delete();
        nwr = 0;
        nrd = 0;
        npop = 0;
    endtask

    task automatic step();
        logic p, o, r;
        @(negedge clk);
        p = wr_pvld & wr_prdy;
        o = rd_pvld & rd_prdy;
        r = ram_re;
        chk("ram_we", ram_we, p);
        if (o) begin
            if (q.size() == 0) chk("pop_empty", 1, 0);
            else chk("rd_pd", rd_pd, q.pop_front());
            npop++;
        end
        if (r) begin
            chk("re_nonempty", (nwr - nrd) > 0, 1);
            chk("ram_ra", ram_ra, nrd % DEPTH);
            nrd++;
        end
        if (p) begin
            chk("ram_wa", ram_wa, nwr % DEPTH);
            chk("ram_di", ram_di, wr_pd);
            q.push_back(wr_pd);
            nwr++;
        end
        last_push = p;
        last_pop = o;
        @(posedge clk);
        #1;
        chk("fifo_cnt", fifo_cnt, q.size());
        chk("outstanding", (nrd - npop) <= 2 && (nrd - npop) >= 0, 1);
        if (q.size() < DEPTH) chk("wr_prdy_room", wr_prdy, 1);
        if (q.size() == DEPTH + 2) chk("wr_prdy_full", wr_prdy, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_pvld = 1'b0;
        rd_prdy = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_pvld", rd_pvld, 0);
        chk("rst_wr_prdy", wr_prdy, 0);
        chk("rst_ram_re", ram_re, 0);
        chk("rst_fifo_cnt", fifo_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain();
        int budget;
        wr_pvld = 1'b0;
        rd_prdy = 1'b1;
        budget = 0;
        while ((q.size() != 0 || fifo_cnt != 0) && budget < 60) begin
            step();
            budget++;
        end
        chk("drain_done", q.size() == 0 && fifo_cnt == 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, budget, gaps;
        logic seen;

        do_reset();
        chk("pwrbus", pwr_o, 0);
        pwr_i = 32'hDEAD_BEEF;
        #1 chk("pwrbus", pwr_o, 32'hDEAD_BEEF);
        step();

        // single-entry latency
        wr_pvld = 1'b1;
        wr_pd = DW'(8'hA5);
        rd_prdy = 1'b1;
        step();
        chk("lat_push", last_push, 1);
        wr_pvld = 1'b0;
        step();
        chk("lat_pvld_early", rd_pvld, 0);
        step();
        chk("lat_pvld", rd_pvld, 1);
        chk("lat_data", rd_pd, DW'(8'hA5));
        step();
        chk("lat_empty", fifo_cnt, 0);

        // fill to capacity with no pops
        rd_prdy = 1'b0;
        wr_pvld = 1'b1;
        k = 0;
        budget = 0;
        while (k < DEPTH + 2 && budget < 100) begin
            wr_pd = DW'(k);
            step();
            if (last_push) k++;
            budget++;
        end
        chk("fill_count", k, DEPTH + 2);
        wr_pd = DW'(999);
        repeat (3) step();
        chk("full_prdy", wr_prdy, 0);
        chk("full_cnt", fifo_cnt, DEPTH + 2);
        wr_pvld = 1'b0;
        rd_prdy = 1'b1;
        step();
        chk("full_first_pop", last_pop, 1);
        chk("full_prdy_back", wr_prdy, 1);
        drain();

        // streaming push+pop every cycle
        wr_pvld = 1'b1;
        rd_prdy = 1'b1;
        seen = 1'b0;
        gaps = 0;
        for (int i = 0; i < 100; i++) begin
            wr_pd = DW'(32'h1000 + i);
            step();
            if (fifo_cnt > 3) chk("stream_cnt", fifo_cnt, 3);
            if (rd_pvld) seen = 1'b1;
            else if (seen) gaps++;
        end
        chk("stream_seen", seen, 1);
        chk("stream_gaps", gaps, 0);
        drain();

        // wrap with random pop pressure
        wr_pvld = 1'b1;
        k = 0;
        budget = 0;
        while (k < 80 && budget < 1000) begin
            wr_pd = rnd_data();
            rd_prdy = $urandom_range(0, 1);
            step();
            if (last_push) k++;
            budget++;
        end
        chk("wrap_count", k, 80);
        drain();

        // mid-operation reset
        rd_prdy = 1'b0;
        wr_pvld = 1'b1;
        budget = 0;
        while (q.size() < 10 && budget < 50) begin
            wr_pd = rnd_data();
            step();
            budget++;
        end
        wr_pvld = 1'b0;
        step();
        chk("pre_rst_cnt", fifo_cnt, 10);
        #2 rst = 1'b1;
        #1;
        chk("arst_rd_pvld", rd_pvld, 0);
        chk("arst_ram_re", ram_re, 0);
        chk("arst_fifo_cnt", fifo_cnt, 0);
        do_reset();
        step();
        wr_pvld = 1'b1;
        wr_pd = DW'(1);
        step();
        wr_pvld = 1'b0;
        rd_prdy = 1'b1;
        repeat (3) step();
        chk("post_rst_pops", npop, 1);
        drain();

        // fully random traffic, biased to keep the buffer full
        for (int i = 0; i < 600; i++) begin
            wr_pvld = ($urandom_range(0, 3) != 0);
            wr_pd = rnd_data();
            rd_prdy = (i < 300) ? ($urandom_range(0, 3) == 0)
                                : $urandom_range(0, 1);
            step();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
